// File: rtl/imem_bank_bootloaded.sv
// Instruction-memory bank: after reset (or a RELOAD request) it copies the boot image one word
// per cycle, then serves combinational reads and guarded writes with a write-protected region.
module imem_bank_bootloaded #(
    parameter int WIDTH         = 16,
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = 4,
    parameter int PROTECT_BASE  = 0,
    parameter int PROTECT_WORDS = 0
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] READ_SELECT,
    output logic [WIDTH-1:0]  IMEM_OUTPUT,
    input  logic [ADDR_W-1:0] WRITE_SELECT,
    input  logic              WRITE_ENABLE,
    input  logic [WIDTH-1:0]  IMEM_INPUT,
    input  logic              RELOAD,
    output logic [ADDR_W-1:0] BOOT_ADDR,
    input  logic [WIDTH-1:0]  BOOT_DATA,
    output logic              BOOT_DONE,
    output logic              WRITE_REJECT
);

    typedef enum logic {ST_BOOT, ST_RUN} state_t;

    localparam logic [31:0]       DEPTH_U    = 32'(DEPTH);
    localparam logic [31:0]       PROT_LO    = 32'(PROTECT_BASE);
    localparam logic [31:0]       PROT_CNT   = 32'(PROTECT_WORDS);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              done_q;
    logic              reject_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic        booting;
    logic [31:0] wsel_ext;
    logic [31:0] rsel_ext;
    logic        wsel_in_range;
    logic        wsel_protected;
    logic        run_wr_ok;
    logic        wr_refused;

    assign booting  = (state_q == ST_BOOT);
    assign wsel_ext = 32'(WRITE_SELECT);
    assign rsel_ext = 32'(READ_SELECT);

    // Unsigned wrap makes indices below the base fall outside the window too.
    assign wsel_in_range  = (wsel_ext < DEPTH_U);
    assign wsel_protected = ((wsel_ext - PROT_LO) < PROT_CNT);

    assign run_wr_ok  = !booting && WRITE_ENABLE && !RELOAD && wsel_in_range && !wsel_protected;
    assign wr_refused = WRITE_ENABLE && !run_wr_ok;

    assign BOOT_ADDR    = booting ? ptr_q : '0;
    assign BOOT_DONE    = done_q;
    assign WRITE_REJECT = reject_q;
    assign IMEM_OUTPUT  = (rsel_ext < DEPTH_U) ? mem_q[READ_SELECT] : '0;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q  <= ST_BOOT;
            ptr_q    <= '0;
            done_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            reject_q <= wr_refused;
            case (state_q)
                ST_BOOT: begin
                    if (ptr_q == LAST_IDX) begin
                        state_q <= ST_RUN;
                        ptr_q   <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (RELOAD) begin
                        state_q <= ST_BOOT;
                        ptr_q   <= '0;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_BOOT;
                    ptr_q   <= '0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Boot copy ignores protection; loader writes only land in RUN.
    always_ff @(posedge CLOCK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (RESET) begin
                mem_q[i] <= '0;
            end else if (booting && (ptr_q == ADDR_W'(i))) begin
                mem_q[i] <= BOOT_DATA;
            end else if (run_wr_ok && (WRITE_SELECT == ADDR_W'(i))) begin
                mem_q[i] <= IMEM_INPUT;
            end
        end
    end

endmodule

// File: tb/tb_imem_bank_bootloaded.sv
// Scoreboard bench for imem_bank_bootloaded: a protected 16-word bank and an unprotected 12-word bank.
module tb_imem_bank_bootloaded;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rd_sel = '0;
    logic [15:0] rd_data;
    logic [3:0]  wr_sel = '0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        reload = 1'b0;
    logic [3:0]  boot_addr;
    logic [15:0] boot_data;
    logic        boot_done;
    logic        wr_reject;

    logic        rst12 = 1'b1;
    logic [3:0]  rd_sel12 = '0;
    logic [15:0] rd_data12;
    logic [3:0]  wr_sel12 = '0;
    logic        wr_en12 = 1'b0;
    logic [3:0]  boot_addr12;
    logic [15:0] boot_data12;
    logic        boot_done12;
    logic        wr_reject12;

    always #5 clk = ~clk;

    assign boot_data   = 16'hA000 | {12'h000, boot_addr};
    assign boot_data12 = 16'hA000 | {12'h000, boot_addr12};

    imem_bank_bootloaded #(.WIDTH(16), .DEPTH(16), .ADDR_W(4), .PROTECT_BASE(0), .PROTECT_WORDS(4)) u_dut (
        .CLOCK(clk), .RESET(rst), .READ_SELECT(rd_sel), .IMEM_OUTPUT(rd_data),
        .WRITE_SELECT(wr_sel), .WRITE_ENABLE(wr_en), .IMEM_INPUT(wr_data), .RELOAD(reload),
        .BOOT_ADDR(boot_addr), .BOOT_DATA(boot_data), .BOOT_DONE(boot_done), .WRITE_REJECT(wr_reject)
    );

    imem_bank_bootloaded #(.WIDTH(16), .DEPTH(12), .ADDR_W(4)) u_dut12 (
        .CLOCK(clk), .RESET(rst12), .READ_SELECT(rd_sel12), .IMEM_OUTPUT(rd_data12),
        .WRITE_SELECT(wr_sel12), .WRITE_ENABLE(wr_en12), .IMEM_INPUT(16'h4321), .RELOAD(1'b0),
        .BOOT_ADDR(boot_addr12), .BOOT_DATA(boot_data12), .BOOT_DONE(boot_done12), .WRITE_REJECT(wr_reject12)
    );

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mdl [16];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int kind);
        case (kind)
            0:       return 32'(rd_data);
            1:       return 32'(boot_addr);
            2:       return 32'(boot_done);
            3:       return 32'(wr_reject);
            4:       return 32'(rd_data12);
            5:       return 32'(boot_addr12);
            6:       return 32'(boot_done12);
            default: return 32'(wr_reject12);
        endcase
    endfunction

    task automatic expect_v(input string tag, input int kind, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.kind = kind; e.exp = v;
        sb.push_back(e);
    endtask

    // Outputs are compared mid-cycle; inputs change just after the rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.kind), e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mdl[i] = '0;
    endtask

    // rsel < 0 sweeps the previously loaded word; abort_at >= 0 asserts RESET in that boot cycle.
    task automatic do_boot(input int we_at, input int rsel, input int abort_at, input logic rej0);
        int r;
        for (int k = 0; k < 16; k++) begin
            rst     = (k == abort_at);
            wr_en   = (k == we_at);
            wr_sel  = 4'd9;
            wr_data = 16'h5555;
            r       = (rsel >= 0) ? rsel : ((k == 0) ? 6 : k - 1);
            rd_sel  = 4'(r);
            expect_v($sformatf("boot_addr k%0d", k), 1, 32'(k));
            expect_v($sformatf("boot_done k%0d", k), 2, 32'd0);
            expect_v($sformatf("boot_read k%0d r%0d", k, r), 0, 32'(mdl[r]));
            expect_v($sformatf("boot_rej k%0d", k), 3, (k == 0) ? 32'(rej0) : 32'(k == we_at + 1));
            cyc();
            if (k == abort_at) begin
                rst   = 1'b0;
                wr_en = 1'b0;
                clear_model();
                return;
            end
            mdl[k] = 16'hA000 | 16'(k);
        end
        wr_en = 1'b0;
        expect_v("boot_done_after", 2, 32'd1);
        expect_v("boot_addr_run", 1, 32'd0);
        expect_v("boot_rej_after", 3, 32'(we_at == 15));
        cyc();
    endtask

    task automatic sweep(input string name);
        for (int i = 0; i < 16; i++) begin
            rd_sel = 4'(i);
            expect_v($sformatf("%s rd%0d", name, i), 0, 32'(mdl[i]));
            cyc();
        end
    endtask

    task automatic run_write(input int sel, input logic [15:0] d, input logic refused);
        wr_en = 1'b1; wr_sel = 4'(sel); wr_data = d; rd_sel = 4'(sel);
        expect_v($sformatf("wr%0d same_cycle", sel), 0, 32'(mdl[sel]));
        cyc();
        wr_en = 1'b0;
        if (!refused) mdl[sel] = d;
        expect_v($sformatf("wr%0d next_read", sel), 0, 32'(mdl[sel]));
        expect_v($sformatf("wr%0d reject", sel), 3, 32'(refused));
        cyc();
        expect_v($sformatf("wr%0d reject_clears", sel), 3, 32'd0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_boot(-1, -1, -1, 1'b0);
        sweep("boot1");

        run_write(5, 16'h1234, 1'b0);
        run_write(3, 16'hFFFF, 1'b1);
        run_write(0, 16'hFFFF, 1'b1);
        run_write(4, 16'hBEEF, 1'b0);
        run_write(15, 16'h0F0F, 1'b0);

        // Reload with a colliding write: the write must be refused.
        reload = 1'b1; wr_en = 1'b1; wr_sel = 4'd6; wr_data = 16'h7777; rd_sel = 4'd5;
        expect_v("reload_cycle_read5", 0, 32'(mdl[5]));
        cyc();
        reload = 1'b0; wr_en = 1'b0;
        do_boot(-1, 5, -1, 1'b1);
        sweep("reload");

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        clear_model();
        do_boot(-1, -1, 7, 1'b0);
        do_boot(2, -1, -1, 1'b0);
        sweep("reboot");

        rst12 = 1'b1;
        cyc();
        rst12 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            expect_v($sformatf("d12 boot_addr k%0d", k), 5, 32'(k));
            expect_v($sformatf("d12 boot_done k%0d", k), 6, 32'd0);
            cyc();
        end
        rd_sel12 = 4'd13; wr_en12 = 1'b1; wr_sel12 = 4'd13;
        expect_v("d12 done", 6, 32'd1);
        expect_v("d12 read13", 4, 32'd0);
        cyc();
        wr_en12 = 1'b0; rd_sel12 = 4'd11;
        expect_v("d12 reject13", 7, 32'd1);
        expect_v("d12 read11", 4, 32'hA00B);
        cyc();
        expect_v("d12 reject_clears", 7, 32'd0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
